// File: rtl/pipe_ctrl_pkg.sv
// Shared state encoding for the pipeline sequencing controller.
// Imported by the controller top and its testbench.
package pipe_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN  = 2'd0,
        ST_MUL  = 2'd1,
        ST_MEMW = 2'd2
    } state_t;

endpackage

// File: rtl/mul_lat_timer.sv
// Loadable down-counter for multiply occupancy.
// Saturates at zero and exposes a zero flag.
module mul_lat_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush/bubble sequencing for the 5-stage core.
// Covers load-use, multiply occupancy, taken branches and dmem waits.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [4:0]         RA_ID,
    input  logic [4:0]         RB_ID,
    input  logic               USE_RA_ID,
    input  logic               USE_RB_ID,
    input  logic [4:0]         RD_EX,
    input  logic               LOAD_EX,
    input  logic               MUL_EX,
    input  logic               BR_TAKEN_EX,
    input  logic               DMEM_WAIT,
    output logic               HOLD_PC,
    output logic               HOLD_IFID,
    output logic               HOLD_IDEX,
    output logic               HOLD_EXMEM,
    output logic               FLUSH_IFID,
    output logic               BUBBLE_IDEX,
    output logic               BUBBLE_EXMEM,
    output logic               BUBBLE_MEMWB,
    output logic [STATE_W-1:0] STATE,
    output logic [CNT_W-1:0]   STALL_CNT
);

    localparam int TW = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
    localparam logic [TW-1:0] MUL_LOAD = TW'(MUL_LAT - 2);

    state_t        state_q;
    state_t        state_nxt;
    logic          tmr_load;
    logic          tmr_dec;
    logic [TW-1:0] tmr_cnt;
    logic          tmr_zero;
    logic          luh;
    logic [CNT_W-1:0] stall_q;

    // r0 is hardwired, so a load targeting it never needs a bubble
    assign luh = LOAD_EX && (RD_EX != 5'd0) &&
                 ((USE_RA_ID && (RA_ID == RD_EX)) ||
                  (USE_RB_ID && (RB_ID == RD_EX)));

    mul_lat_timer #(.W(TW)) u_timer (
        .clk      (CLK),
        .rst_n    (RST_N),
        .load     (tmr_load),
        .load_val (MUL_LOAD),
        .dec      (tmr_dec),
        .cnt      (tmr_cnt),
        .zero     (tmr_zero)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        HOLD_PC      = 1'b0;
        HOLD_IFID    = 1'b0;
        HOLD_IDEX    = 1'b0;
        HOLD_EXMEM   = 1'b0;
        FLUSH_IFID   = 1'b0;
        BUBBLE_IDEX  = 1'b0;
        BUBBLE_EXMEM = 1'b0;
        BUBBLE_MEMWB = 1'b0;
        state_nxt    = state_q;
        tmr_load     = 1'b0;
        tmr_dec      = 1'b0;
        if (RST_N) begin
            unique case (state_q)
                // MEMW shares RUN evaluation once the wait drops
                ST_RUN, ST_MEMW: begin
                    if (DMEM_WAIT) begin
                        HOLD_PC      = 1'b1;
                        HOLD_IFID    = 1'b1;
                        HOLD_IDEX    = 1'b1;
                        HOLD_EXMEM   = 1'b1;
                        BUBBLE_MEMWB = 1'b1;
                        state_nxt    = ST_MEMW;
                    end else begin
                        state_nxt = ST_RUN;
                        if (MUL_EX) begin
                            HOLD_PC      = 1'b1;
                            HOLD_IFID    = 1'b1;
                            HOLD_IDEX    = 1'b1;
                            BUBBLE_EXMEM = 1'b1;
                            tmr_load     = 1'b1;
                            state_nxt    = ST_MUL;
                        end else if (BR_TAKEN_EX) begin
                            FLUSH_IFID  = 1'b1;
                            BUBBLE_IDEX = 1'b1;
                        end else if (luh) begin
                            HOLD_PC     = 1'b1;
                            HOLD_IFID   = 1'b1;
                            BUBBLE_IDEX = 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    // multiplier keeps counting even while frozen
                    tmr_dec = !tmr_zero;
                    if (DMEM_WAIT) begin
                        HOLD_PC      = 1'b1;
                        HOLD_IFID    = 1'b1;
                        HOLD_IDEX    = 1'b1;
                        HOLD_EXMEM   = 1'b1;
                        BUBBLE_MEMWB = 1'b1;
                    end else if (!tmr_zero) begin
                        HOLD_PC      = 1'b1;
                        HOLD_IFID    = 1'b1;
                        HOLD_IDEX    = 1'b1;
                        BUBBLE_EXMEM = 1'b1;
                    end else begin
                        state_nxt = ST_RUN;
                    end
                end
                default: state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            stall_q <= '0;
        end else if (HOLD_PC && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign STATE     = state_q;
    assign STALL_CNT = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl.
// A second instance with a 4-bit counter covers saturation.
module tb_pipeline_ctrl;

    localparam logic [7:0] C_NONE = 8'b0000_0000;
    localparam logic [7:0] C_LUH  = 8'b1100_0100;
    localparam logic [7:0] C_BR   = 8'b0000_1100;
    localparam logic [7:0] C_MUL  = 8'b1110_0010;
    localparam logic [7:0] C_FRZ  = 8'b1111_0001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] ra_id, rb_id, rd_ex;
    logic       use_ra, use_rb, load_ex, mul_ex, br_ex, dmem_wait;

    logic hpc, hifid, hidex, hexmem, fifid, bidex, bexmem, bmemwb;
    logic [1:0]  state;
    logic [15:0] stall_cnt;
    logic s_hpc, s_hifid, s_hidex, s_hexmem, s_fifid, s_bidex, s_bexmem, s_bmemwb;
    logic [1:0] s_state;
    logic [3:0] s_stall_cnt;
    logic [7:0] ctl, s_ctl;

    int n_cmp = 0;
    int n_err = 0;
    int exp_stall = 0;

    always #5 clk = ~clk;

    assign ctl = {hpc, hifid, hidex, hexmem, fifid, bidex, bexmem, bmemwb};
    assign s_ctl = {s_hpc, s_hifid, s_hidex, s_hexmem,
                    s_fifid, s_bidex, s_bexmem, s_bmemwb};

    pipeline_ctrl #(.MUL_LAT(4), .CNT_W(16)) dut (
        .CLK(clk), .RST_N(rst_n), .RA_ID(ra_id), .RB_ID(rb_id),
        .USE_RA_ID(use_ra), .USE_RB_ID(use_rb), .RD_EX(rd_ex),
        .LOAD_EX(load_ex), .MUL_EX(mul_ex), .BR_TAKEN_EX(br_ex),
        .DMEM_WAIT(dmem_wait), .HOLD_PC(hpc), .HOLD_IFID(hifid),
        .HOLD_IDEX(hidex), .HOLD_EXMEM(hexmem), .FLUSH_IFID(fifid),
        .BUBBLE_IDEX(bidex), .BUBBLE_EXMEM(bexmem), .BUBBLE_MEMWB(bmemwb),
        .STATE(state), .STALL_CNT(stall_cnt)
    );

    pipeline_ctrl #(.MUL_LAT(4), .CNT_W(4)) u_sat (
        .CLK(clk), .RST_N(rst_n), .RA_ID(ra_id), .RB_ID(rb_id),
        .USE_RA_ID(use_ra), .USE_RB_ID(use_rb), .RD_EX(rd_ex),
        .LOAD_EX(load_ex), .MUL_EX(mul_ex), .BR_TAKEN_EX(br_ex),
        .DMEM_WAIT(dmem_wait), .HOLD_PC(s_hpc), .HOLD_IFID(s_hifid),
        .HOLD_IDEX(s_hidex), .HOLD_EXMEM(s_hexmem), .FLUSH_IFID(s_fifid),
        .BUBBLE_IDEX(s_bidex), .BUBBLE_EXMEM(s_bexmem),
        .BUBBLE_MEMWB(s_bmemwb), .STATE(s_state), .STALL_CNT(s_stall_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ra_id = 5'd0; rb_id = 5'd0; rd_ex = 5'd0;
        use_ra = 1'b0; use_rb = 1'b0; load_ex = 1'b0;
        mul_ex = 1'b0; br_ex = 1'b0; dmem_wait = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        dmem_wait = 1'b1;
        mul_ex = 1'b1;
        #2;
        n_cmp++;
        if (ctl !== C_NONE) begin
            n_err++;
            $display("FAIL rst_ctl: got %b want %b", ctl, C_NONE);
        end
        n_cmp++;
        if (s_ctl !== C_NONE) begin
            n_err++;
            $display("FAIL rst_sat_ctl: got %b want %b", s_ctl, C_NONE);
        end
        step();
        n_cmp++;
        if (state !== 2'd0) begin
            n_err++;
            $display("FAIL rst_state: got %0d want 0", state);
        end
        n_cmp++;
        if (stall_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL rst_stall: got %0d want 0", stall_cnt);
        end
        rst_n = 1'b1;
        clear_inputs();
        #2;
        n_cmp++;
        if (ctl !== C_NONE) begin
            n_err++;
            $display("FAIL idle_ctl: got %b want %b", ctl, C_NONE);
        end
        step();
    endtask

    task automatic test_load_use();
        load_ex = 1'b1; rd_ex = 5'd5; ra_id = 5'd5; use_ra = 1'b1;
        #2;
        n_cmp++;
        if (ctl !== C_LUH) begin
            n_err++;
            $display("FAIL luh_ra_ctl: got %b want %b", ctl, C_LUH);
        end
        step();
        exp_stall = 1;
        load_ex = 1'b0;
        #2;
        n_cmp++;
        if (ctl !== C_NONE) begin
            n_err++;
            $display("FAIL luh_clear_ctl: got %b want %b", ctl, C_NONE);
        end
        n_cmp++;
        if (stall_cnt !== 16'(exp_stall)) begin
            n_err++;
            $display("FAIL luh_stall: got %0d want %0d", stall_cnt, exp_stall);
        end
        step();
        load_ex = 1'b1; rd_ex = 5'd0; ra_id = 5'd0;
        #2;
        n_cmp++;
        if (ctl !== C_NONE) begin
            n_err++;
            $display("FAIL luh_r0_ctl: got %b want %b", ctl, C_NONE);
        end
        step();
        rd_ex = 5'd7; ra_id = 5'd7; use_ra = 1'b0;
        rb_id = 5'd3; use_rb = 1'b1;
        #2;
        n_cmp++;
        if (ctl !== C_NONE) begin
            n_err++;
            $display("FAIL luh_unused_ctl: got %b want %b", ctl, C_NONE);
        end
        step();
        rb_id = 5'd7;
        #2;
        n_cmp++;
        if (ctl !== C_LUH) begin
            n_err++;
            $display("FAIL luh_rb_ctl: got %b want %b", ctl, C_LUH);
        end
        step();
        exp_stall = 2;
        clear_inputs();
    endtask

    task automatic test_branch();
        load_ex = 1'b1; rd_ex = 5'd5; ra_id = 5'd5; use_ra = 1'b1;
        br_ex = 1'b1;
        #2;
        n_cmp++;
        if (ctl !== C_BR) begin
            n_err++;
            $display("FAIL br_luh_ctl: got %b want %b", ctl, C_BR);
        end
        step();
        clear_inputs();
        #2;
        n_cmp++;
        if (stall_cnt !== 16'(exp_stall)) begin
            n_err++;
            $display("FAIL br_stall: got %0d want %0d", stall_cnt, exp_stall);
        end
        step();
    endtask

    task automatic test_mul();
        logic [1:0] st_exp [4];
        logic [7:0] c_exp [4];
        st_exp = '{2'd0, 2'd1, 2'd1, 2'd1};
        c_exp = '{C_MUL, C_MUL, C_MUL, C_NONE};
        mul_ex = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            n_cmp++;
            if (state !== st_exp[i]) begin
                n_err++;
                $display("FAIL mul_state[%0d]: got %0d want %0d",
                         i, state, st_exp[i]);
            end
            n_cmp++;
            if (ctl !== c_exp[i]) begin
                n_err++;
                $display("FAIL mul_ctl[%0d]: got %b want %b", i, ctl, c_exp[i]);
            end
            step();
        end
        mul_ex = 1'b0;
        exp_stall += 3;
        #2;
        n_cmp++;
        if (state !== 2'd0) begin
            n_err++;
            $display("FAIL mul_exit_state: got %0d want 0", state);
        end
        n_cmp++;
        if (stall_cnt !== 16'(exp_stall)) begin
            n_err++;
            $display("FAIL mul_stall: got %0d want %0d", stall_cnt, exp_stall);
        end
        step();
    endtask

    task automatic test_mem_wait();
        logic [1:0] st_exp [3];
        st_exp = '{2'd0, 2'd2, 2'd2};
        dmem_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            n_cmp++;
            if (ctl !== C_FRZ) begin
                n_err++;
                $display("FAIL memw_ctl[%0d]: got %b want %b", i, ctl, C_FRZ);
            end
            n_cmp++;
            if (state !== st_exp[i]) begin
                n_err++;
                $display("FAIL memw_state[%0d]: got %0d want %0d",
                         i, state, st_exp[i]);
            end
            step();
        end
        dmem_wait = 1'b0;
        mul_ex = 1'b1;
        #2;
        n_cmp++;
        if (state !== 2'd2 || ctl !== C_MUL) begin
            n_err++;
            $display("FAIL memw_release: got st=%0d ctl=%b want st=2 ctl=%b",
                     state, ctl, C_MUL);
        end
        step();
        #2;
        n_cmp++;
        if (state !== 2'd1 || ctl !== C_MUL) begin
            n_err++;
            $display("FAIL memw_mul1: got st=%0d ctl=%b want st=1 ctl=%b",
                     state, ctl, C_MUL);
        end
        step();
        #2;
        n_cmp++;
        if (ctl !== C_MUL) begin
            n_err++;
            $display("FAIL memw_mul2: got %b want %b", ctl, C_MUL);
        end
        step();
        #2;
        n_cmp++;
        if (ctl !== C_NONE) begin
            n_err++;
            $display("FAIL memw_mul3: got %b want %b", ctl, C_NONE);
        end
        step();
        mul_ex = 1'b0;
        exp_stall += 6;
        #2;
        n_cmp++;
        if (state !== 2'd0) begin
            n_err++;
            $display("FAIL memw_exit_state: got %0d want 0", state);
        end
        n_cmp++;
        if (stall_cnt !== 16'(exp_stall)) begin
            n_err++;
            $display("FAIL memw_stall: got %0d want %0d", stall_cnt, exp_stall);
        end
        step();
    endtask

    task automatic test_mul_wait();
        mul_ex = 1'b1;
        step();
        step();
        step();
        dmem_wait = 1'b1;
        #2;
        n_cmp++;
        if (ctl !== C_FRZ) begin
            n_err++;
            $display("FAIL mulw_ctl0: got %b want %b", ctl, C_FRZ);
        end
        step();
        #2;
        n_cmp++;
        if (state !== 2'd1 || ctl !== C_FRZ) begin
            n_err++;
            $display("FAIL mulw_hold: got st=%0d ctl=%b want st=1 ctl=%b",
                     state, ctl, C_FRZ);
        end
        step();
        dmem_wait = 1'b0;
        #2;
        n_cmp++;
        if (state !== 2'd1 || ctl !== C_NONE) begin
            n_err++;
            $display("FAIL mulw_go: got st=%0d ctl=%b want st=1 ctl=%b",
                     state, ctl, C_NONE);
        end
        step();
        mul_ex = 1'b0;
        exp_stall += 5;
        #2;
        n_cmp++;
        if (state !== 2'd0) begin
            n_err++;
            $display("FAIL mulw_exit_state: got %0d want 0", state);
        end
        step();
    endtask

    task automatic test_branch_freeze();
        dmem_wait = 1'b1;
        br_ex = 1'b1;
        #2;
        n_cmp++;
        if (ctl !== C_FRZ) begin
            n_err++;
            $display("FAIL brf_frozen: got %b want %b", ctl, C_FRZ);
        end
        step();
        dmem_wait = 1'b0;
        #2;
        n_cmp++;
        if (ctl !== C_BR) begin
            n_err++;
            $display("FAIL brf_flush: got %b want %b", ctl, C_BR);
        end
        step();
        clear_inputs();
        exp_stall += 1;
        #2;
        n_cmp++;
        if (state !== 2'd0 || stall_cnt !== 16'(exp_stall)) begin
            n_err++;
            $display("FAIL brf_after: got st=%0d cnt=%0d want st=0 cnt=%0d",
                     state, stall_cnt, exp_stall);
        end
        step();
    endtask

    task automatic test_reset_mid_mul();
        mul_ex = 1'b1;
        step();
        step();
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if (state !== 2'd1) begin
            n_err++;
            $display("FAIL rmm_pre_state: got %0d want 1", state);
        end
        n_cmp++;
        if (ctl !== C_NONE) begin
            n_err++;
            $display("FAIL rmm_ctl: got %b want %b", ctl, C_NONE);
        end
        step();
        n_cmp++;
        if (state !== 2'd0 || stall_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL rmm_after: got st=%0d cnt=%0d want st=0 cnt=0",
                     state, stall_cnt);
        end
        rst_n = 1'b1;
        mul_ex = 1'b0;
        exp_stall = 0;
        #2;
        n_cmp++;
        if (ctl !== C_NONE) begin
            n_err++;
            $display("FAIL rmm_idle: got %b want %b", ctl, C_NONE);
        end
        step();
    endtask

    task automatic test_saturation();
        dmem_wait = 1'b1;
        for (int i = 0; i < 20; i++) step();
        exp_stall = 20;
        #2;
        n_cmp++;
        if (s_stall_cnt !== 4'd15) begin
            n_err++;
            $display("FAIL sat_cnt: got %0d want 15", s_stall_cnt);
        end
        n_cmp++;
        if (stall_cnt !== 16'(exp_stall)) begin
            n_err++;
            $display("FAIL sat_main_cnt: got %0d want %0d", stall_cnt, exp_stall);
        end
        n_cmp++;
        if (s_ctl !== C_FRZ || s_state !== 2'd2) begin
            n_err++;
            $display("FAIL sat_frz: got st=%0d ctl=%b want st=2 ctl=%b",
                     s_state, s_ctl, C_FRZ);
        end
        step();
        dmem_wait = 1'b0;
        step();
        #2;
        n_cmp++;
        if (s_stall_cnt !== 4'd15 || state !== 2'd0) begin
            n_err++;
            $display("FAIL sat_hold: got cnt=%0d st=%0d want cnt=15 st=0",
                     s_stall_cnt, state);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mul();
        test_mem_wait();
        test_mul_wait();
        test_branch_freeze();
        test_reset_mid_mul();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
